// File: rtl/bool_truth_table_sweeper_if.sv
// Connection bundle between the truth-table sweeper, its test/config master and
// the Boolean function unit under evaluation.
interface bool_truth_table_sweeper_if;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic        w;
    logic        x;
    logic        y;
    logic        z;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  minterm_cnt;
    logic        mismatch;
    logic [3:0]  first_fail_idx;

    modport master (
        output start, abort, expected, f_in,
        input  w, x, y, z, busy, done, truth_table, minterm_cnt, mismatch, first_fail_idx
    );

    modport slave (
        input  start, abort, expected, f_in,
        output w, x, y, z, busy, done, truth_table, minterm_cnt, mismatch, first_fail_idx
    );
endinterface

// File: rtl/bool_truth_table_sweeper.sv
// Walks all 16 vectors of a 4-input function unit, captures its truth table,
// counts minterms and flags the first disagreement with a golden table.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep held
// RUN   | driving vec_idx, sampling f_in once per vector after the settle time
// DONE  | one-cycle completion pulse, vector returned to 0
module bool_truth_table_sweeper #(
    parameter int EVAL_LATENCY = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bool_truth_table_sweeper_if.slave    bus
);

    localparam int SW = (EVAL_LATENCY > 0) ? $clog2(EVAL_LATENCY + 1) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(EVAL_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    vec_idx;
    logic [SW-1:0] settle;
    logic [15:0]   exp_q;
    logic          busy_q;
    logic          done_q;
    logic [15:0]   truth_table_q;
    logic [4:0]    minterm_cnt_q;
    logic          mismatch_q;
    logic [3:0]    first_fail_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec_idx          <= '0;
            settle           <= '0;
            exp_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            truth_table_q    <= '0;
            minterm_cnt_q    <= '0;
            mismatch_q       <= 1'b0;
            first_fail_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_q            <= bus.expected;
                        truth_table_q    <= '0;
                        minterm_cnt_q    <= '0;
                        mismatch_q       <= 1'b0;
                        first_fail_idx_q <= '0;
                        vec_idx          <= '0;
                        settle           <= '0;
                        busy_q           <= 1'b1;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    // abort beats a coinciding sample edge: partial results stay as they are
                    if (bus.abort) begin
                        vec_idx <= '0;
                        settle  <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (settle == SETTLE_MAX) begin
                        truth_table_q[vec_idx] <= bus.f_in;
                        minterm_cnt_q          <= minterm_cnt_q + {4'd0, bus.f_in};
                        if ((bus.f_in != exp_q[vec_idx]) && !mismatch_q) begin
                            mismatch_q       <= 1'b1;
                            first_fail_idx_q <= vec_idx;
                        end
                        settle <= '0;
                        if (vec_idx == 4'd15) begin
                            vec_idx <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            vec_idx <= vec_idx + 4'd1;
                        end
                    end else begin
                        settle <= settle + SW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {bus.w, bus.x, bus.y, bus.z} = vec_idx;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.truth_table    = truth_table_q;
    assign bus.minterm_cnt    = minterm_cnt_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.first_fail_idx = first_fail_idx_q;

endmodule
